// File: rtl/montgomery_mult_serial.sv
// Bit-serial radix-2 Montgomery multiplier: Z = A*B*2^-N mod M.
// Each multiply takes N loop cycles, one reduction cycle and one done cycle.
module montgomery_mult_serial #(
  parameter int N = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] M,
  output logic [N-1:0] Z,
  output logic         busy,
  output logic         done
);

  localparam int IW = $clog2(N) + 1;

  typedef enum logic [1:0] {IDLE, LOOP, FINAL, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   a_reg, b_reg, m_reg;
  logic [N+1:0]   s_reg;
  logic [IW-1:0]  i_reg;
  logic [N-1:0]   z_reg;

  // One radix-2 step; S < 2M keeps S + B + M below 4M, so N+2 bits suffice.
  function automatic logic [N+1:0] mont_step(input logic [N+1:0] s,
                                             input logic         a0,
                                             input logic [N-1:0] b,
                                             input logic [N-1:0] m);
    logic [N+1:0] t;
    t = s + (a0 ? {2'b00, b} : '0);
    if (t[0])
      t = t + {2'b00, m};
    return t >> 1;
  endfunction

  function automatic logic [N-1:0] final_reduce(input logic [N+1:0] s,
                                                input logic [N-1:0] m);
    logic [N+1:0] d;
    d = s - {2'b00, m};
    if (s >= {2'b00, m})
      return d[N-1:0];
    return s[N-1:0];
  endfunction

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = LOOP;
      LOOP:    if (i_reg == IW'(N - 1)) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      s_reg <= '0;
      i_reg <= '0;
      z_reg <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            s_reg <= '0;
            i_reg <= '0;
          end
        end
        LOOP: begin
          s_reg <= mont_step(s_reg, a_reg[0], b_reg, m_reg);
          i_reg <= i_reg + IW'(1);
        end
        FINAL:   z_reg <= final_reduce(s_reg, m_reg);
        default: ;
      endcase
    end
  end

  // Operand copies: latched on an accepted start, multiplicand shifts out LSB-first.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      a_reg <= A;
      b_reg <= B;
      m_reg <= M;
    end else if (state == LOOP) begin
      a_reg <= a_reg >> 1;
    end
  end

  assign Z    = z_reg;
  assign busy = (state != IDLE) && !reset;
  assign done = (state == DONE) && !reset;

endmodule

// File: tb/tb_montgomery_mult_serial.sv
// Bench for montgomery_mult_serial: N=8 instance against a modular-arithmetic
// model checked every cycle, plus one N=4096 conversion of 1 into Montgomery form.
module tb_montgomery_mult_serial;

  localparam int N8 = 8;
  localparam int NB = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start8 = 1'b0;
  logic [N8-1:0] a8 = '0, b8 = '0, m8 = 8'hF1;
  logic [N8-1:0] z8;
  logic busy8, done8;

  logic start4 = 1'b0;
  logic [NB-1:0] a4 = '0, b4 = '0, m4 = '0;
  logic [NB-1:0] z4;
  logic busy4, done4;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  montgomery_mult_serial #(.N(N8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .M(m8),
    .Z(z8), .busy(busy8), .done(done8));

  montgomery_mult_serial #(.N(NB)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .A(a4), .B(b4), .M(m4),
    .Z(z4), .busy(busy4), .done(done4));

  // A*B*R^-1 mod M with R = 2^8, R^-1 found by search.
  function automatic logic [7:0] mont_ref(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] m);
    longint rinv = 0;
    for (longint x = 1; x < longint'(m); x++)
      if (((x * 256) % longint'(m)) == 1) rinv = x;
    return 8'((((longint'(a) * longint'(b)) % longint'(m)) * rinv) % longint'(m));
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing model: k counts edges since the accepted start (0 = idle).
  int k = 0;
  logic [7:0] exp_z = '0, pend = '0;

  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      exp_z = '0;
    end else if (k == 0) begin
      if (start8) begin
        pend = mont_ref(a8, b8, m8);
        k = 1;
      end
    end else begin
      k++;
      if (k == N8 + 2) exp_z = pend;
      if (k == N8 + 3) k = 0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("busy", 64'(busy8), 64'((k != 0) && !reset));
      check("done", 64'(done8), 64'((k == N8 + 2) && !reset));
      check("z",    64'(z8),    64'(exp_z));
    end
  end

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input bit no_wait, output logic [7:0] z,
                        output int lat, output int bcnt);
    int guard;
    if (!no_wait) @(negedge clk);
    a8 = a; b8 = b; m8 = m; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    bcnt = busy8 ? 1 : 0;
    z = 'x;
    while (!done8 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (busy8) bcnt++;
    end
    if (lat >= 200) check("done_timeout", 64'(lat), 64'(N8 + 1));
    z = z8;
    guard = 0;
    while (busy8 && guard < 200) begin
      @(negedge clk);
      guard++;
      if (busy8) bcnt++;
    end
  endtask

  initial begin
    logic [7:0] z, ma, a, b, exp1;
    int lat, bcnt, dcnt, ok;
    logic [NB:0] x, mm;
    logic [NB-1:0] rmod;

    // Model pinned to hand-computed values for M = 0xF1.
    check("model_1x1",   64'(mont_ref(8'h01, 8'h01, 8'hF1)), 64'h E1);
    check("model_conv",  64'(mont_ref(8'h07, 8'hE1, 8'hF1)), 64'h 69);
    check("model_r",     64'(mont_ref(8'h0F, 8'h2A, 8'hF1)), 64'h 2A);
    check("model_minus", 64'(mont_ref(8'hF0, 8'hF0, 8'hF1)), 64'h E1);

    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy8), 64'h0);
    check("rst_done", 64'(done8), 64'h0);
    check("rst_z",    64'(z8),    64'h0);
    reset = 1'b0;
    chk_en = 1'b1;

    run_op(8'h01, 8'h01, 8'hF1, 1'b0, z, lat, bcnt);
    check("basic_z", 64'(z), 64'h E1);
    check("basic_latency", 64'(lat), 64'd9);
    check("basic_busy_cycles", 64'(bcnt), 64'd10);

    run_op(8'h07, 8'hE1, 8'hF1, 1'b0, z, lat, bcnt);
    check("conv_z", 64'(z), 64'h69);
    run_op(8'h0F, 8'h2A, 8'hF1, 1'b0, z, lat, bcnt);
    check("r_z", 64'(z), 64'h2A);
    run_op(8'hF0, 8'hF0, 8'hF1, 1'b0, z, lat, bcnt);
    check("edge_z", 64'(z), 64'hE1);
    run_op(8'h00, 8'hC3, 8'hF1, 1'b0, z, lat, bcnt);
    check("zero_z", 64'(z), 64'h00);

    // Start re-pulsed at cycles 3 and 9 of a run must be ignored.
    @(negedge clk);
    a8 = 8'h07; b8 = 8'hE1; m8 = 8'hF1; start8 = 1'b1;
    dcnt = 0;
    z = '0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (done8) begin dcnt++; z = z8; end
      if (c == 3 || c == 9) begin
        a8 = 8'($urandom_range(0, 240)); b8 = 8'($urandom_range(0, 240)); start8 = 1'b1;
      end
    end
    start8 = 1'b0;
    check("busy_start_done_count", 64'(dcnt), 64'd1);
    check("busy_start_z", 64'(z), 64'h69);

    // Back-to-back: second start presented as soon as busy falls.
    run_op(8'h01, 8'h01, 8'hF1, 1'b0, z, lat, bcnt);
    check("b2b_first_z", 64'(z), 64'hE1);
    run_op(8'hF0, 8'h0F, 8'hF1, 1'b1, z, lat, bcnt);
    check("b2b_second_z", 64'(z), 64'(mont_ref(8'hF0, 8'h0F, 8'hF1)));
    check("b2b_second_latency", 64'(lat), 64'd9);

    // Reset in LOOP cycle 4 aborts with no done.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h44; m8 = 8'hF1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy8), 64'h0);
    check("abort_z",    64'(z8),    64'h0);
    reset = 1'b0;
    dcnt = 0;
    repeat (14) begin
      @(negedge clk);
      if (done8) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);
    run_op(8'h01, 8'h01, 8'hF1, 1'b0, z, lat, bcnt);
    check("after_abort_z", 64'(z), 64'hE1);

    // Randomized operands under random odd moduli with top bit set.
    for (int t = 0; t < 40; t++) begin
      ma = 8'($urandom_range(128, 255)) | 8'h01;
      a = 8'($urandom_range(0, int'(ma) - 1));
      b = 8'($urandom_range(0, int'(ma) - 1));
      exp1 = mont_ref(a, b, ma);
      run_op(a, b, ma, (t % 3) == 0, z, lat, bcnt);
      check("rand_z", 64'(z), 64'(exp1));
    end

    // Full width: A=1, B=R^2 mod M gives R mod M.
    for (int j = 0; j < NB / 32; j++) m4[j*32 +: 32] = $urandom;
    m4[NB-1] = 1'b1;
    m4[0] = 1'b1;
    mm = {1'b0, m4};
    x = (NB+1)'(1) << NB;
    x = x - mm;
    rmod = x[NB-1:0];
    for (int j = 0; j < NB; j++) begin
      x = x << 1;
      if (x >= mm) x = x - mm;
    end
    @(negedge clk);
    a4 = NB'(1); b4 = x[NB-1:0]; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < NB + 50) begin
      @(negedge clk);
      lat++;
    end
    check("wide_latency", 64'(lat), 64'(NB + 1));
    n_vec++;
    if (z4 !== rmod) begin
      n_bad++;
      $display("FAIL wide_z: low bits got %0h expected %0h", z4[63:0], rmod[63:0]);
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/montgomery_mult_serial.md
# montgomery_mult_serial

Bit-serial radix-2 Montgomery multiplier computing Z = A·B·2^-N mod M for the RSA decryption datapath. Sits directly downstream of the Montgomery-constant stage: that stage's R² mod M output (`R_t`) is fed in as operand B to convert plaintext and ciphertext words into the Montgomery domain. The same block then performs every modular multiply of the exponentiation loop. Operands are loaded on a single start pulse, and a one-cycle `done` pulse marks a valid result.

## Interface

**Parameters**
- `N`, default 4096: operand and modulus width in bits. The Montgomery radix is R = 2^N.

**Ports**
- `clk`, input, 1 bit: the only clock. All logic is rising-edge.
- `reset`, input, 1 bit: synchronous, active-high.
- `start`, input, 1 bit: a request pulse, sampled only in IDLE.
- `A`, input, N bits: multiplicand. Must be < M.
- `B`, input, N bits: multiplier. Must be < M. Typically `R_t` or a prior Z.
- `M`, input, N bits: modulus. Must be odd and have bit N-1 = 1.
- `Z`, output, N bits: result A·B·R^-1 mod M. Always < M.
- `busy`, output, 1 bit: high from the cycle after start is accepted until `done` is deasserted.
- `done`, output, 1 bit: a one-cycle pulse. Z is valid from this cycle until the next accepted start.

## Operation

- **Internal registers**
  - Operand copies `a_reg`, `b_reg`, `m_reg` (N bits each), captured at start.
  - Accumulator `S` (N+2 bits).
  - Bit counter `i` (clog2(N)+1 bits).
- **FSM states:** IDLE, LOOP, FINAL, DONE.
  - **IDLE.** On `start`=1: latch A/B/M, set S=0 and i=0, then go to LOOP. Otherwise stay in IDLE.
  - **LOOP** (exactly N cycles). Each cycle:
    - T = S + (a_reg[0] ? b_reg : 0)
    - if T[0] = 1, then T = T + m_reg
    - S ← T >> 1
    - a_reg ← a_reg >> 1
    - i ← i + 1
    - When i = N-1 in this cycle, the next state is FINAL.
  - **FINAL** (1 cycle). If S ≥ m_reg, then Z ← S − m_reg; else Z ← S[N-1:0]. Next state is DONE.
  - **DONE** (1 cycle). `done`=1, then return to IDLE.
- **Width rule.** With A, B < M, S < 2M throughout, so N+2 bits never overflow. Intermediate T needs N+2 bits, so all additions are carried out at N+2 bits.
- **Start while busy.** `start` asserted in LOOP, FINAL or DONE is ignored. It is not queued.
- **Operand stability.** Inputs may change freely after the start cycle, because the operand copies are latched.
- **Out-of-contract inputs.** If M is even or an operand is ≥ M, Z is undefined. There is no error flag.
- **Reset.**
  - Reset has priority over start.
  - While reset is high: state = IDLE, `busy`=0, `done`=0, Z=0, S=0, i=0.
  - Reset during LOOP or FINAL aborts the operation. No `done` pulse is issued and Z reads 0.

## Timing

- Define t0 as the edge at which `start`=1 is sampled in IDLE.
- `busy` rises after t0.
- LOOP occupies edges t0+1 … t0+N.
- FINAL completes at edge t0+N+1, which is when Z updates.
- `done`=1 during the cycle following edge t0+N+1.
- IDLE is re-entered at edge t0+N+2, which is also when `busy` falls.
- Total latency from the start edge to `done` high is N+1 edges.
- Back-to-back operation: the earliest next start is sampled at t0+N+2. The throughput is one multiply per N+2 cycles.
- Z holds its value while in IDLE, and only changes at a FINAL edge or on reset.

## Test plan

Use N=8, M=0xF1 (241) unless stated otherwise. For this modulus, R mod M = 0x0F, R² mod M = 0xE1, and R^-1 mod M = 0xE1.

1. **Basic multiply.** A=0x01, B=0x01, pulse start → `done` arrives 9 edges after the start edge, Z=0xE1, and `busy` is high for exactly 10 cycles.
2. **Domain conversion.** A=0x07, B=0xE1 (R² mod M) → Z=0x69 (7·R mod M). Then A=0x0F, B=0x2A → Z=0x2A.
3. **Edge operands and final subtraction.** A=0xF0, B=0xF0 → Z=0xE1. A=0x00, B=0xC3 → Z=0x00.
4. **Start while busy, and back-to-back.**
   - Re-pulse start with new operands at cycles 3 and 9 of a run → the first result is unaffected and only one `done` pulse occurs.
   - Start exactly at the `busy`-fall edge → accepted, and the second result is correct.
5. **Reset mid-operation.**
   - Assert reset in LOOP cycle 4 → `busy`=0, `done` never pulses, Z=0.
   - After release, A=0x01, B=0x01 → Z=0xE1.
6. **Full width with N=4096.** Use M equal to the Montgomery-constant stage's test modulus, with B = that stage's `R_t` and A=1 → Z = R mod M, which must equal that stage's R output reduced to 4096 bits. `done` arrives 4097 edges after the start edge.
